lsu_mem_adapter: RTL and testbench

Load/store adapter between the core's load/store pipeline stage and the word-wide synchronous data `memory` block. It accepts one byte, halfword or word request at a time. Loads return aligned, sign- or zero-extended data. Sub-word stores use a read-modify-write sequence, because the memory only writes full words. Misaligned, invalid-size and out-of-range requests are reported as errors and never reach memory.

---
 rtl/lsu_mem_adapter.sv | 208 ++++++++++++++++++++
 tb/tb_lsu_mem_adapter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_adapter.sv
// Load/store adapter between the core LSU stage and a word-wide synchronous memory.
// Handles sub-word loads with extension and sub-word stores via read-modify-write.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 12
`endif

module lsu_mem_adapter #(
  parameter int unsigned MEM_ADDR_WIDTH = `MEM_ADDR_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned HI_LSB = MEM_ADDR_WIDTH + 2;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_LDRET  = 3'd2;
  localparam logic [2:0] S_RMW_WR = 3'd3;
  localparam logic [2:0] S_WR     = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;

  logic        r_we;
  logic        r_unsigned;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;

  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_rw;

  logic        w_resp_valid_nxt;
  logic        w_resp_err_nxt;
  logic [31:0] w_resp_rdata_nxt;
  logic [31:0] w_mem_addr_nxt;
  logic [31:0] w_mem_wdata_nxt;
  logic        w_mem_rw_nxt;

  logic        w_accept;
  logic        w_range_err;
  logic        w_req_err;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;
  logic [31:0] w_merge;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign req_ready = (r_state == S_IDLE);

  // Any byte address at or above the memory size is out of range.
  assign w_range_err = (HI_LSB < 32) ? ((req_addr >> HI_LSB) != 32'd0) : 1'b0;

  assign w_req_err = (req_size == SZ_X)
                   || ((req_size == SZ_H) && req_addr[0])
                   || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00))
                   || w_range_err;

  // Lane selection and extension of returning load data.
  always_comb begin
    w_ld_byte = 8'(mem_rdata >> {r_off, 3'b000});
    w_ld_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_ld_data = mem_rdata;
    case (r_size)
      SZ_B:    w_ld_data = {{24{w_ld_byte[7] & ~r_unsigned}}, w_ld_byte};
      SZ_H:    w_ld_data = {{16{w_ld_half[15] & ~r_unsigned}}, w_ld_half};
      default: w_ld_data = mem_rdata;
    endcase
  end

  // Replace the addressed byte/half of the read word with store data.
  always_comb begin
    w_merge = mem_rdata;
    if (r_size == SZ_B) begin
      case (r_off)
        2'd0:    w_merge = {mem_rdata[31:8], r_wdata[7:0]};
        2'd1:    w_merge = {mem_rdata[31:16], r_wdata[7:0], mem_rdata[7:0]};
        2'd2:    w_merge = {mem_rdata[31:24], r_wdata[7:0], mem_rdata[15:0]};
        default: w_merge = {r_wdata[7:0], mem_rdata[23:0]};
      endcase
    end else if (r_size == SZ_H) begin
      w_merge = r_off[1] ? {r_wdata[15:0], mem_rdata[15:0]}
                         : {mem_rdata[31:16], r_wdata[15:0]};
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = 1'b0;
    w_resp_rdata_nxt = 32'd0;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_mem_rw_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_req_err) begin
            w_state_nxt = S_ERR;
          end else if (req_we && (req_size == SZ_W)) begin
            w_state_nxt     = S_WR;
            w_mem_addr_nxt  = {req_addr[31:2], 2'b00};
            w_mem_wdata_nxt = req_wdata;
            w_mem_rw_nxt    = 1'b1;
          end else begin
            w_state_nxt    = S_RD;
            w_mem_addr_nxt = {req_addr[31:2], 2'b00};
          end
        end
      end
      S_RD: begin
        if (r_we) begin
          w_state_nxt  = S_RMW_WR;
          w_mem_rw_nxt = 1'b1;
        end else begin
          w_state_nxt = S_LDRET;
        end
      end
      S_LDRET: begin
        w_state_nxt      = S_IDLE;
        w_resp_valid_nxt = 1'b1;
        w_resp_rdata_nxt = w_ld_data;
      end
      S_RMW_WR: begin
        w_state_nxt      = S_IDLE;
        w_resp_valid_nxt = 1'b1;
        w_mem_wdata_nxt  = w_merge;
      end
      S_WR: begin
        w_state_nxt      = S_IDLE;
        w_resp_valid_nxt = 1'b1;
      end
      S_ERR: begin
        w_state_nxt      = S_IDLE;
        w_resp_valid_nxt = 1'b1;
        w_resp_err_nxt   = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= 2'b00;
      r_off        <= 2'b00;
      r_wdata      <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_rw     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_mem_rw     <= w_mem_rw_nxt;
      if (w_accept) begin
        r_we       <= req_we;
        r_unsigned <= req_unsigned;
        r_size     <= req_size;
        r_off      <= req_addr[1:0];
        r_wdata    <= req_wdata;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_addr   = r_mem_addr;
  assign mem_rw     = r_mem_rw;
  // The merged word depends on read data that only arrives in the write cycle.
  assign mem_wdata  = (r_state == S_RMW_WR) ? w_merge : r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Directed scoreboard bench for lsu_mem_adapter with a behavioural word memory.
module tb_lsu_mem_adapter;

  localparam int unsigned AW = 8;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;

  lsu_mem_adapter #(.MEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: registered read, write-on-mem_rw.
  logic [31:0] mem [0:(1<<AW)-1];
  int wr_cnt = 0;
  always @(posedge clk) begin
    if (mem_rw) begin
      mem[mem_addr[AW+1:2]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    mem_rdata <= mem[mem_addr[AW+1:2]];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          acc_q[$];
  logic [31:0] model [int];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mword(input logic [31:0] a);
    if (model.exists(int'(a[31:2]))) return model[int'(a[31:2])];
    return 32'h0;
  endfunction

  function automatic logic exp_err(input logic [1:0] sz, input logic [31:0] a);
    logic e;
    e = (sz == 2'b11);
    if (sz == 2'b01 && a[0]) e = 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00) e = 1'b1;
    if (a >= (32'd1 << (AW + 2))) e = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] r;
    w = mword(a);
    case (sz)
      2'b00: begin
        r = (w >> (8 * a[1:0])) & 32'hFF;
        if (!uns && r[7]) r = r | 32'hFFFFFF00;
      end
      2'b01: begin
        r = (w >> (16 * a[1])) & 32'hFFFF;
        if (!uns && r[15]) r = r | 32'hFFFF0000;
      end
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] exp_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w;
    logic [31:0] m;
    w = mword(a);
    case (sz)
      2'b00: begin
        m = 32'hFF << (8 * a[1:0]);
        return (w & ~m) | ((wd & 32'hFF) << (8 * a[1:0]));
      end
      2'b01: begin
        m = 32'hFFFF << (16 * a[1]);
        return (w & ~m) | ((wd & 32'hFFFF) << (16 * a[1]));
      end
      default: return wd;
    endcase
  endfunction

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
  endtask

  // One request, called at a negedge with the adapter idle; returns at the response cycle.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input string tag);
    exp_t        e;
    exp_t        got_e;
    logic        err;
    logic        exp_rw;
    logic [31:0] nw;
    bit          got;
    err     = exp_err(sz, a);
    nw      = exp_store(sz, a, wd);
    e.err   = err;
    e.rdata = exp_rd;
    e.lat   = (err || (we && sz == 2'b10)) ? 2 : 3;
    sb_q.push_back(e);
    if (we && !err) model[int'(a[31:2])] = nw;
    drive(we, sz, uns, a, wd);
    req_valid = 1'b1;
    chk({tag, "/ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    got = 1'b0;
    for (int k = 1; k <= 6 && !got; k++) begin
      exp_rw = !err && we && ((sz == 2'b10 && k == 1) || (sz != 2'b10 && k == 2));
      chk($sformatf("%s/mem_rw@%0d", tag, k), 32'(mem_rw), 32'(exp_rw));
      if (!err && k == 1) chk({tag, "/mem_addr"}, mem_addr, {a[31:2], 2'b00});
      if (exp_rw) chk({tag, "/mem_wdata"}, mem_wdata, nw);
      if (resp_valid) begin
        got   = 1'b1;
        got_e = sb_q.pop_front();
        chk({tag, "/latency"}, 32'(k), 32'(got_e.lat));
        chk({tag, "/rdata"}, resp_rdata, got_e.rdata);
        chk({tag, "/err"}, 32'(resp_err), 32'(got_e.err));
      end else begin
        @(negedge clk);
      end
    end
    chk({tag, "/response_seen"}, 32'(got), 32'd1);
    if (!got && sb_q.size() > 0) void'(sb_q.pop_front());
  endtask

  logic        b_we   [4];
  logic [1:0]  b_sz   [4];
  logic [31:0] b_addr [4];
  logic [31:0] b_wd   [4];

  initial begin
    int   w0;
    int   idx;
    int   last_resp;
    exp_t e;
    exp_t got_e;

    reset = 1'b1; req_valid = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'd0, 32'd0);

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst/resp_valid", 32'(resp_valid), 32'd0);
    chk("rst/resp_err", 32'(resp_err), 32'd0);
    chk("rst/resp_rdata", resp_rdata, 32'd0);
    chk("rst/mem_addr", mem_addr, 32'd0);
    chk("rst/mem_wdata", mem_wdata, 32'd0);
    chk("rst/mem_rw", 32'(mem_rw), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst/req_ready", 32'(req_ready), 32'd1);

    // Word store then load.
    w0 = wr_cnt;
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, "sw10");
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "lw10");
    chk("sw_lw/write_count", 32'(wr_cnt - w0), 32'd1);

    // Byte store merge.
    run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0, "sw20");
    w0 = wr_cnt;
    run_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, 32'h0, "sb22");
    chk("sb22/write_count", 32'(wr_cnt - w0), 32'd1);
    run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11AA3344, "lw20");
    chk("sb22/mem_word", mem[8], 32'h11AA3344);

    // Load extension.
    run_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h80FF7F01, 32'h0, "sw30");
    run_req(1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 32'h0000007F, "lb31");
    run_req(1'b0, 2'b00, 1'b0, 32'h32, 32'h0, 32'hFFFFFFFF, "lb32");
    run_req(1'b0, 2'b00, 1'b1, 32'h32, 32'h0, 32'h000000FF, "lbu32");
    run_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 32'hFFFF80FF, "lh32");
    run_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 32'h000080FF, "lhu32");
    run_req(1'b0, 2'b00, 1'b0, 32'h33, 32'h0, 32'hFFFFFF80, "lb33");
    run_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 32'h00007F01, "lh30");

    // Errors never reach memory.
    w0 = wr_cnt;
    run_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, "err_lw13");
    run_req(1'b1, 2'b01, 1'b0, 32'h15, 32'hBEEF, 32'h0, "err_sh15");
    run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, "err_size11");
    run_req(1'b0, 2'b10, 1'b0, 32'h1 << (AW + 2), 32'h0, 32'h0, "err_range_ld");
    run_req(1'b1, 2'b10, 1'b0, 32'h1 << (AW + 2), 32'h12345678, 32'h0, "err_range_st");
    chk("err/write_count", 32'(wr_cnt - w0), 32'd0);
    chk("err/mem10", mem[4], mword(32'h10));

    // Back-to-back alternating sb/lw with req_valid held high.
    run_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h01020304, 32'h0, "sw40");
    @(negedge clk);
    b_we[0] = 1'b1; b_sz[0] = 2'b00; b_addr[0] = 32'h41; b_wd[0] = 32'h5A;
    b_we[1] = 1'b0; b_sz[1] = 2'b10; b_addr[1] = 32'h40; b_wd[1] = 32'h0;
    b_we[2] = 1'b1; b_sz[2] = 2'b00; b_addr[2] = 32'h43; b_wd[2] = 32'hC3;
    b_we[3] = 1'b0; b_sz[3] = 2'b10; b_addr[3] = 32'h40; b_wd[3] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      e.err   = 1'b0;
      e.lat   = 3;
      e.rdata = b_we[i] ? 32'h0 : exp_load(b_sz[i], 1'b0, b_addr[i]);
      if (b_we[i]) model[int'(b_addr[i][31:2])] = exp_store(b_sz[i], b_addr[i], b_wd[i]);
      sb_q.push_back(e);
    end
    idx = 0;
    last_resp = -1;
    drive(b_we[0], b_sz[0], 1'b0, b_addr[0], b_wd[0]);
    req_valid = 1'b1;
    for (int c = 0; c < 60 && (idx < 4 || sb_q.size() > 0); c++) begin
      if (resp_valid) begin
        got_e = sb_q.pop_front();
        chk($sformatf("b2b/latency%0d", c), 32'(c - acc_q.pop_front()), 32'(got_e.lat));
        chk($sformatf("b2b/rdata%0d", c), resp_rdata, got_e.rdata);
        chk($sformatf("b2b/err%0d", c), 32'(resp_err), 32'(got_e.err));
        last_resp = c;
      end
      if (req_valid && req_ready) begin
        if (idx > 0) chk($sformatf("b2b/accept%0d", idx), 32'(c), 32'(last_resp));
        acc_q.push_back(c);
        idx++;
      end
      @(negedge clk);
      if (idx < 4) drive(b_we[idx], b_sz[idx], 1'b0, b_addr[idx], b_wd[idx]);
      else req_valid = 1'b0;
    end
    chk("b2b/all_responses", 32'(sb_q.size()), 32'd0);
    chk("b2b/all_accepted", 32'(idx), 32'd4);
    chk("b2b/mem40", mem[16], 32'hC3025A04);
    sb_q.delete();
    acc_q.delete();

    // Reset during the read phase of a byte store.
    @(negedge clk);
    w0 = wr_cnt;
    drive(1'b1, 2'b00, 1'b0, 32'h21, 32'h77);
    req_valid = 1'b1;
    @(negedge clk);
    chk("rmw_rst/rd_mem_rw", 32'(mem_rw), 32'd0);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rmw_rst/resp_valid%0d", k), 32'(resp_valid), 32'd0);
      chk($sformatf("rmw_rst/mem_rw%0d", k), 32'(mem_rw), 32'd0);
      chk($sformatf("rmw_rst/mem_addr%0d", k), mem_addr, 32'd0);
      chk($sformatf("rmw_rst/mem_wdata%0d", k), mem_wdata, 32'd0);
      chk($sformatf("rmw_rst/resp_rdata%0d", k), resp_rdata, 32'd0);
      chk($sformatf("rmw_rst/resp_err%0d", k), 32'(resp_err), 32'd0);
      @(negedge clk);
    end
    chk("rmw_rst/req_ready", 32'(req_ready), 32'd1);
    chk("rmw_rst/write_count", 32'(wr_cnt - w0), 32'd0);
    run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11AA3344, "rmw_rst/lw20");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
